// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit 7-segment scanner with frame-synchronous digit capture
// Ports: clk, reset (async, active-high); number0..number3 BCD digits (number0 = rightmost);
//        blank forces display dark; an one-hot digit enable; seg {dp,g,f,e,d,c,b,a}, active-high.
// Params: SCAN_DIV clk cycles per digit slot (>=2); DP_POS digit with lit decimal point (4..7 = none).
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int DP_POS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] number0,
  input  logic [3:0] number1,
  input  logic [3:0] number2,
  input  logic [3:0] number3,
  input  logic       blank,
  output logic [3:0] an,
  output logic [7:0] seg
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [15:0][6:0] SEG_LUT = {{6{7'h40}}, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                          7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0] an_d;
  logic [7:0] seg_d;
  logic tick, dp, lz_blank, dark;
  logic [3:0] dig;
`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] hi_zero;
  // hi_zero[k]: digit k and everything above it are zero; digit 0 is never suppressed
  assign hi_zero = {~|sh_q[3], ~|{sh_q[3], sh_q[2]}, ~|{sh_q[3], sh_q[2], sh_q[1]}, 1'b0};
  assign lz_blank = hi_zero[idx_q] && (DP_POS >= 4 || int'(idx_q) > DP_POS);
`else
  assign lz_blank = 1'b0;
`endif
  always_comb begin
    tick    = presc_q == PW'(SCAN_DIV - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q + {1'b0, tick};
    // new digits are latched only as the scan wraps so a frame never mixes two values
    sh_d    = (tick && idx_q == 2'd3) ? {number3, number2, number1, number0} : sh_q;
    dig     = sh_q[idx_q];
    dp      = int'(idx_q) == DP_POS;
    dark    = blank || lz_blank;
    an_d    = dark ? 4'b0000 : 4'b0001 << idx_q;
    seg_d   = dark ? 8'h00 : {dp, SEG_LUT[dig]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      an      <= '0;
      seg     <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      an      <= an_d;
      seg     <= seg_d;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver against a cycle-count reference model
module tb_seg_scan_driver;
  localparam int D  = 4;
  localparam int DP = 3;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk = 1'b0, reset = 1'b1, blank = 1'b0;
  logic [3:0] number0, number1, number2, number3;
  logic [3:0] an;
  logic [7:0] seg;
  int n_chk = 0, n_fail = 0;
  int t = 0;
  int sh [4] = '{0, 0, 0, 0};
  logic [11:0] exp_q [$];

  seg_scan_driver #(.SCAN_DIV(D), .DP_POS(DP)) dut (
    .clk(clk), .reset(reset), .number0(number0), .number1(number1),
    .number2(number2), .number3(number3), .blank(blank), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: an/seg got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [11:0] expect_out(int s, logic b);
    bit lz = 0;
    if (b) return 12'h000;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && (DP >= 4 || s > DP)) begin
      lz = 1;
      for (int k = s; k < 4; k++) if (sh[k] != 0) lz = 0;
    end
`endif
    if (lz) return 12'h000;
    return {4'(1 << s), s == DP, sh[s] > 9 ? 7'h40 : PAT[sh[s]]};
  endfunction

  // reference model: slot follows elapsed cycles since reset, frame snapshot every 4*D cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0;
      sh = '{0, 0, 0, 0};
    end else begin
      exp_q.push_back(expect_out((t / D) % 4, blank));
      if (t % (4 * D) == 4 * D - 1) sh = '{int'(number0), int'(number1), int'(number2), int'(number3)};
      t++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      check("reset", {an, seg}, 12'h000);
    end else if (exp_q.size() > 0) begin
      check("scan", {an, seg}, exp_q.pop_front());
    end
  end

  task automatic nums(input int a, input int b, input int c, input int d);
    {number0, number1, number2, number3} = {4'(a), 4'(b), 4'(c), 4'(d)};
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    nums(1, 2, 3, 4);
    cyc(3);
    #1 reset = 1'b0;
    cyc(48);
    cyc(5);
    number0 = 4'd7;
    cyc(40);
    cyc(3);
    blank = 1'b1;
    cyc(10);
    blank = 1'b0;
    cyc(24);
    nums(4, 3, 2, 0);
    cyc(36);
    number1 = 4'd12;
    cyc(36);
    nums(5, 0, 0, 0);
    cyc(40);
    nums(0, 0, 9, 0);
    cyc(40);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        nums($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15),
             $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15),
             $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15),
             $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      cyc(1);
    end
    blank = 1'b0;
    nums(8, 6, 1, 3);
    cyc(40);
    for (int i = 0; i < 64 && (t / D) % 4 != 2; i++) cyc(1);
    check("find_idx2", 12'((t / D) % 4), 12'd2);
    #2 reset = 1'b1;
    #1 check("reset_async", {an, seg}, 12'h000);
    cyc(2);
    #1 reset = 1'b0;
    cyc(50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (>=2); 1 kHz digit rate at 100 MHz.
REQ-002 SHALL have parameter DP_POS, default 4, digit index whose decimal point is lit; 4..7 means no decimal point.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports number0..number3  input  4 each  BCD digits from the counter; number0 is least significant.
REQ-006 SHALL have port blank  input  1  level; 1 forces the display dark.
REQ-007 SHALL have port an  output  4  active-high one-hot digit enable; an[k] selects digit k, an[0] rightmost.
REQ-008 SHALL have port seg  output  8  active-high segments {dp,g,f,e,d,c,b,a}.

Function
REQ-009 SHALL keep prescaler 0..SCAN_DIV-1 incrementing every cycle; tick asserted when prescaler is SCAN_DIV-1; prescaler then wraps to 0.
REQ-010 SHALL keep 2-bit scan index advancing by 1 on each tick, wrapping 3->0.
REQ-011 SHALL copy number0..3 into shadow registers only on the tick where index wraps 3->0; inputs changing at any other time SHALL NOT affect the current frame.
REQ-012 SHALL register an and seg; they reflect the index and shadow contents of the previous cycle (1-cycle latency).
REQ-013 SHALL decode shadow digit at index: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, seg[6:0]).
REQ-014 SHALL decode shadow values 10..15 as a dash, seg[6:0]=40.
REQ-015 SHALL set seg[7] when index equals DP_POS, else clear it.
REQ-016 SHALL drive an=0000 and seg=00 the cycle after blank is sampled 1; prescaler, index and shadow loading SHALL continue during blank.
REQ-017 SHALL resume normal an/seg the cycle after blank is sampled 0, at the current index with no restart.
REQ-018 SHALL keep exactly one an bit high whenever not blanked and not in reset.

Reset
REQ-019 SHALL, on reset assertion, immediately clear prescaler, index, shadow digits, an (0000) and seg (00), regardless of clk.
REQ-020 SHALL, on the first clk edge after reset release with blank=0, drive an=0001 and seg=3F (shadow zero, DP_POS default).
REQ-021 SHALL restart scanning from index 0 with prescaler 0 when reset is asserted mid-frame.

Configuration
REQ-022 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-023 With LEADING_ZERO_BLANK_EN defined, digit k (1..3) SHALL show an[k]=0, seg=00 during its slot when shadow digits k..3 are all zero and k > DP_POS (any k 1..3 when DP_POS>=4); digit 0 never blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be displayed, zeros included.

Verification (SCAN_DIV=4 unless stated)
REQ-025 Reset release, numbers=1,2,3,4 (number0..3) -> first frame shows 0 on all digits; from second frame an=0001/seg=06, 0010/5B, 0100/4F, 1000/66, each held 4 cycles.
REQ-026 Change number0 from 1 to 7 mid-frame -> digit 0 keeps 06 until next 3->0 wrap, then 07.
REQ-027 blank=1 for 10 cycles mid-scan -> an=0000, seg=00 from next cycle; release -> scanning continues at index that prescaler/index timing dictates.
REQ-028 DP_POS=3, numbers 4,3,2,0 -> digit 3 slot shows seg=BF (dp lit), others dp clear; value 12 on number1 -> seg=40.
REQ-029 LEADING_ZERO_BLANK_EN, numbers 5,0,0,0 -> only an=0001/seg=6D slot active, other slots an=0000; without macro -> all four slots, zeros as 3F.
REQ-030 Assert reset during index 2 -> an=0000, seg=00 immediately; after release scan starts at an=0001.
